// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the fetch/load-store memory bus arbiter.
// MEM_ARB_ROUND_ROBIN_EN selects alternating grants under contention.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_REQ   = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_LOCAL = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory port between fetch and load/store sides.
// MEM_ARB_ROUND_ROBIN_EN: alternate grants when both sides contend.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam owner_e OWNER_RST = OWNER_DATA;
`else
  localparam owner_e OWNER_RST = OWNER_INST;
`endif

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;

  logic pick_data;
  logic done_bus;
  logic done_local;

  always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    pick_data = data_req && (!inst_req || owner_q == OWNER_INST);
`else
    pick_data = data_req;
`endif
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    done_bus     = 1'b0;
    done_local   = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_data) begin
          data_addr_ok = 1'b1;
          owner_d      = OWNER_DATA;
          addr_d       = data_addr;
          wr_d         = data_wr;
          wstrb_d      = data_wstrb;
          wdata_d      = data_wdata;
          // a store with no enabled bytes never reaches the bus
          state_d = (data_wr && data_wstrb == '0)
                  ? ARB_LOCAL : ARB_REQ;
        end else if (inst_req) begin
          inst_addr_ok = 1'b1;
          owner_d      = OWNER_INST;
          addr_d       = inst_addr;
          wr_d         = 1'b0;
          wstrb_d      = '0;
          wdata_d      = '0;
          state_d      = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            done_bus = 1'b1;
            state_d  = ARB_IDLE;
          end else begin
            state_d = ARB_WAIT;
          end
        end
      end
      ARB_WAIT: begin
        if (bus_data_ok) begin
          done_bus = 1'b1;
          state_d  = ARB_IDLE;
        end
      end
      ARB_LOCAL: begin
        done_local = 1'b1;
        state_d    = ARB_IDLE;
      end
    endcase
  end

  always_comb begin
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    if (done_bus && owner_q == OWNER_INST) inst_rdata_d = bus_rdata;
    if (done_bus && owner_q == OWNER_DATA) data_rdata_d = bus_rdata;
  end

  assign inst_data_ok = done_bus && owner_q == OWNER_INST;
  assign data_data_ok = (done_bus || done_local)
                     && owner_q == OWNER_DATA;
  assign inst_rdata   = inst_rdata_d;
  assign data_rdata   = data_rdata_d;

  assign bus_req   = state_q == ARB_REQ;
  assign bus_wr    = wr_q;
  assign bus_wstrb = wstrb_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign busy      = state_q != ARB_IDLE;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWNER_RST;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter against a transaction-level model.
// Honours MEM_ARB_ROUND_ROBIN_EN for the contended-grant rule.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        busy;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) u_dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_wstrb    (bus_wstrb),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RST_LAST_DATA = 1'b1;
`else
  localparam bit RST_LAST_DATA = 1'b0;
`endif

  // outstanding transaction as the model sees it
  bit          t_valid;
  bit          t_data;
  bit          t_local;
  bit          t_accepted;
  bit          t_wr;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic [3:0]  t_wstrb;
  bit          last_data;
  int          resp_cnt;
  logic [31:0] mem [16];
  bit          i_granted;
  bit          d_granted;
  bit          rst_now;
  bit          post_rst;
  int          resets_left;
  int          n_local;
  int          n_same;
  int          n_contend;

  task automatic drive();
    bit exp_req;
    resetn = 1'b1;
    if (!inst_req || i_granted) begin
      i_granted = 1'b0;
      inst_req  = $urandom_range(0, 2) != 0;
      inst_addr = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
    end
    if (!data_req || d_granted) begin
      d_granted  = 1'b0;
      data_req   = $urandom_range(0, 2) != 0;
      data_wr    = 1'($urandom_range(0, 1));
      data_wstrb = ($urandom_range(0, 3) == 0)
                 ? 4'h0 : 4'($urandom_range(0, 15));
      data_addr  = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
      data_wdata = $urandom;
    end
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = $urandom;
    exp_req = t_valid && !t_local && !t_accepted;
    if (t_accepted) begin
      if (resp_cnt == 0) begin
        bus_data_ok = 1'b1;
        bus_rdata   = mem[t_addr[5:2]];
      end else begin
        resp_cnt--;
      end
    end else begin
      bus_addr_ok = 1'($urandom_range(0, 1));
      if (exp_req && bus_addr_ok && $urandom_range(0, 2) == 0) begin
        bus_data_ok = 1'b1;
        bus_rdata   = mem[t_addr[5:2]];
      end else if (!(exp_req && bus_addr_ok)
                   && $urandom_range(0, 7) == 0) begin
        bus_data_ok = 1'b1;
      end
    end
    // abandon an in-flight transaction with a synchronous reset
    if (t_accepted && resets_left > 0 && $urandom_range(0, 19) == 0) begin
      resetn      = 1'b0;
      bus_data_ok = 1'b0;
      rst_now     = 1'b1;
      resets_left--;
    end else if (post_rst) begin
      bus_data_ok = 1'b1;
      post_rst    = 1'b0;
    end
  endtask

  task automatic cycle_check();
    bit exp_ia, exp_da, exp_req, done, pd;
    exp_ia = 1'b0;
    exp_da = 1'b0;
    if (!t_valid && (inst_req || data_req)) begin
      pd = data_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      pd = data_req && (!inst_req || !last_data);
`endif
      if (inst_req && data_req) n_contend++;
      exp_da = pd;
      exp_ia = !pd;
    end
    check("addr_ok", {inst_addr_ok, data_addr_ok}, {exp_ia, exp_da});
    exp_req = t_valid && !t_local && !t_accepted;
    check("bus_req", bus_req, exp_req);
    if (exp_req) begin
      check("bus_addr", bus_addr, t_addr);
      check("bus_wr", bus_wr, t_wr);
      check("bus_wstrb", bus_wstrb, t_wstrb);
      if (t_wr) check("bus_wdata", bus_wdata, t_wdata);
    end
    check("busy", busy, t_valid);
    done = t_valid && (t_local || (t_accepted && bus_data_ok)
                       || (exp_req && bus_addr_ok && bus_data_ok));
    if (done && t_local) n_local++;
    if (done && exp_req) n_same++;
    check("data_ok", {inst_data_ok, data_data_ok},
          {done && !t_data, done && t_data});
    if (done && !t_wr && !t_data)
      check("inst_rdata", inst_rdata, mem[t_addr[5:2]]);
    if (done && !t_wr && t_data)
      check("data_rdata", data_rdata, mem[t_addr[5:2]]);
    if (exp_req && bus_addr_ok) begin
      if (t_wr)
        for (int b = 0; b < 4; b++)
          if (t_wstrb[b]) mem[t_addr[5:2]][8*b +: 8] = t_wdata[8*b +: 8];
      if (!done) begin
        t_accepted = 1'b1;
        resp_cnt   = $urandom_range(0, 3);
      end
    end
    if (done) t_valid = 1'b0;
    if (exp_ia || exp_da) begin
      t_valid    = 1'b1;
      t_data     = exp_da;
      t_accepted = 1'b0;
      last_data  = exp_da;
      t_addr     = exp_da ? data_addr : inst_addr;
      t_wr       = exp_da && data_wr;
      t_wstrb    = exp_da ? data_wstrb : 4'h0;
      t_wdata    = data_wdata;
      t_local    = exp_da && data_wr && data_wstrb == 4'h0;
      i_granted  = exp_ia;
      d_granted  = exp_da;
    end
    if (rst_now) begin
      rst_now    = 1'b0;
      post_rst   = 1'b1;
      t_valid    = 1'b0;
      t_accepted = 1'b0;
      last_data  = RST_LAST_DATA;
    end
  endtask

  initial begin
    resetn      = 1'b0;
    inst_req    = 1'b0;
    inst_addr   = '0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_wstrb  = '0;
    data_addr   = '0;
    data_wdata  = '0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = '0;
    t_valid     = 1'b0;
    t_accepted  = 1'b0;
    t_local     = 1'b0;
    last_data   = RST_LAST_DATA;
    resets_left = 4;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_bus_wr", bus_wr, 1'b0);
    check("rst_bus_wstrb", bus_wstrb, 4'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
    check("rst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    check("rst_inst_rdata", inst_rdata, 32'h0);
    check("rst_data_rdata", data_rdata, 32'h0);
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      cycle_check();
    end
    check("cov_local_seen", 64'(n_local > 0), 64'd1);
    check("cov_same_cycle_seen", 64'(n_same > 0), 64'd1);
    check("cov_contend_seen", 64'(n_contend > 0), 64'd1);
    check("cov_resets_done", 64'(resets_left < 4), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like external memory port between the instruction-fetch side and the data-access (load/store) side of the CPU.
- Sits below the mem stage, which supplies the already-aligned byte-enable mask and address.
- Grants one requester at a time and keeps at most one transaction outstanding.
- Forwards the completion/read data back to the owner and flags busy so the pipeline can stall.

Parameters:
- ADDR_W, 32, address width of requests and bus.
- DATA_W, 32, data width; the byte-enable mask is DATA_W/8 bits wide.

Ports:
- clk  input  1  single clock, rising edge
- resetn  input  1  synchronous active-low reset
- inst_req  input  1  fetch request; held until inst_addr_ok
- inst_addr  input  ADDR_W  fetch address
- inst_addr_ok  output  1  fetch request accepted (one-cycle pulse)
- inst_data_ok  output  1  fetch data valid (one-cycle pulse)
- inst_rdata  output  DATA_W  fetch read data
- data_req  input  1  load/store request; held until data_addr_ok
- data_wr  input  1  1 = store, 0 = load
- data_wstrb  input  DATA_W/8  store byte enables from the mem stage
- data_addr  input  ADDR_W  load/store address
- data_wdata  input  DATA_W  store data
- data_addr_ok  output  1  load/store accepted (pulse)
- data_data_ok  output  1  load data valid / store complete (pulse)
- data_rdata  output  DATA_W  load read data (raw word; mem stage extracts)
- bus_req  output  1  external request valid
- bus_wr  output  1  external write
- bus_wstrb  output  DATA_W/8  external byte enables
- bus_addr  output  ADDR_W  external address
- bus_wdata  output  DATA_W  external write data
- bus_addr_ok  input  1  external request accepted
- bus_data_ok  input  1  external response valid
- bus_rdata  input  DATA_W  external read data
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE, owner=INST.
  - All bus_* and *_ok outputs 0, busy 0.
  - Latched request registers cleared.
- Reset mid-transaction: abandon it; any bus_data_ok arriving later while IDLE is ignored and not forwarded.
- FSM states:
  - IDLE: no transaction in flight.
  - REQ: bus_req asserted, waiting for bus_addr_ok.
  - WAIT: waiting for bus_data_ok.
  - LOCAL: zero-strobe store being completed without a bus transaction.
- IDLE transitions:
  - If data_req=1, grant DATA; otherwise grant INST if inst_req=1. Fixed priority: data over instruction.
  - In the grant cycle, pulse the winner's *_addr_ok combinationally.
  - Latch addr, wr, wstrb, wdata and owner (for fetches, wr=0 and wstrb=0).
  - Go to REQ.
  - The loser sees no addr_ok and must keep its req asserted.
- Zero-strobe store: data_wr=1 with data_wstrb=0 is granted normally but goes to LOCAL instead of REQ. LOCAL pulses data_data_ok for one cycle, then returns to IDLE. No bus activity.
- REQ:
  - bus_req=1; bus_* driven from the latched registers only (never straight from requester inputs).
  - On bus_addr_ok: drop bus_req next cycle and go to WAIT.
  - If bus_addr_ok and bus_data_ok arrive in the same cycle, complete directly: forward data_ok, go to IDLE.
- WAIT: on bus_data_ok, pulse owner's *_data_ok combinationally that same cycle, with *_rdata=bus_rdata; then go to IDLE.
- Non-owner outputs: *_data_ok is never asserted for the non-owner. *_rdata holds the last value when not valid.
- Latency:
  - Grant to bus_req: 1 cycle.
  - Back-to-back transactions have one IDLE bubble between completion and the next grant.
  - Minimum round trip is 3 cycles (grant, REQ with addr_ok+data_ok, IDLE).
- Stray responses: bus_data_ok in IDLE or REQ without bus_addr_ok is a protocol error and is ignored.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - When both requests are pending in IDLE, grant the side not granted last (owner register); single requests are granted immediately.
  - Reset sets last-granted = DATA, so the first contended grant goes to INST.
- Undefined: fixed data-over-instruction priority as above.

Decomposition:
- Shared package/header holds:
  - State encodings ARB_IDLE=2'd0, ARB_REQ=2'd1, ARB_WAIT=2'd2, ARB_LOCAL=2'd3.
  - Owner encodings OWNER_INST=1'b0, OWNER_DATA=1'b1.
- No sub-module; the grant logic is small enough to stay inline in one module.

Test Plan:
1. Single load: data_req, data_wr=0, addr 0x8000_0010; bus_addr_ok 1 cycle after bus_req; bus_data_ok with 0xDEADBEEF 2 cycles later -> data_data_ok pulse, data_rdata=0xDEADBEEF, busy drops next cycle, inst_* silent.
2. Contention: inst_req and data_req both high in IDLE (macro off) -> data_addr_ok first; inst_addr_ok 1 cycle after data_data_ok. With macro on, second contended grant alternates.
3. Store: wstrb=4'b1100, wdata 0x1234_5678, addr 0x8000_0002 -> bus_wr=1, bus_wstrb=4'b1100, bus_addr/wdata match, held stable while bus_addr_ok=0 for 5 cycles.
4. Zero-strobe store: data_wr=1, data_wstrb=0 -> bus_req never asserted, data_data_ok 1 cycle after data_addr_ok.
5. Same-cycle addr_ok/data_ok on a fetch -> inst_data_ok that cycle, state IDLE next.
6. resetn=0 while in WAIT, then bus_data_ok after reset -> no *_data_ok, all outputs 0, next request granted normally.
